// File: rtl/spi_apb_initiator.sv
// APB3 initiator: one valid/ready command in, one APB transfer out, one response back.
// Optional ACCESS-phase timeout enabled by defining SPI_APB_INIT_TIMEOUT_EN.
module spi_apb_initiator #(
  parameter int APB_DWIDTH     = 8,
  parameter int APB_AWIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_AWIDTH-1:0] cmd_addr,
  input  logic [APB_DWIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DWIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_AWIDTH-1:0] paddr,
  output logic [APB_DWIDTH-1:0] pwdata,
  input  logic [APB_DWIDTH-1:0] prdata,
  input  logic                  pready,
  output logic [1:0]            dbg_state
);

  // Handshakes: a command transfers when cmd_valid & cmd_ready at a rising edge,
  // a response when rsp_valid & rsp_ready; rsp_valid/rsp_rdata/rsp_err hold until then.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [APB_AWIDTH-1:0]   paddr_q, paddr_d;
  logic [APB_DWIDTH-1:0]   pwdata_q, pwdata_d;
  logic [APB_DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    timeout;

`ifdef SPI_APB_INIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts ACCESS cycles spent waiting; restarts whenever a transfer enters ACCESS.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !pready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign timeout = (state_q == ACCESS) && !pready && (cnt_q == TO_LAST);

  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready in the last allowed cycle still counts as a normal completion
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (timeout) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule
